// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Holds the decoded operands and control for EX, detects load-use hazards
// against the instruction currently in ID, and generates the forwarding
// selects for the rs-side and rt-side ALU source muxes.
module id_ex_fwd_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_reg_dst,
    input  logic               id_alu_src,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               exmem_reg_write,
    input  logic [REG_AW-1:0]  exmem_rd,
    input  logic               memwb_reg_write,
    input  logic [REG_AW-1:0]  memwb_rd,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_dest,
    output logic               ex_alu_src,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [1:0]         Ctrl_FwdA,
    output logic [1:0]         Ctrl_FwdB,
    output logic               stall
);

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;

    logic               valid_q,     valid_d;
    logic [DATA_W-1:0]  rs_data_q,   rs_data_d;
    logic [DATA_W-1:0]  rt_data_q,   rt_data_d;
    logic [DATA_W-1:0]  imm_q,       imm_d;
    logic [REG_AW-1:0]  rs_q,        rs_d;
    logic [REG_AW-1:0]  rt_q,        rt_d;
    logic [REG_AW-1:0]  dest_q,      dest_d;
    logic               alu_src_q,   alu_src_d;
    logic               mem_read_q,  mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic [ALUOP_W-1:0] alu_op_q,    alu_op_d;

    logic               load_use;
    logic               bubble;

    // The EX/MEM result is newer than MEM/WB, so it wins when both match.
    // $0 is hardwired to zero and must never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic              ex_v,
        input logic [REG_AW-1:0] src,
        input logic              em_rw,
        input logic [REG_AW-1:0] em_rd,
        input logic              mw_rw,
        input logic [REG_AW-1:0] mw_rd
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (ex_v) begin
            if (em_rw && (em_rd != '0) && (em_rd == src)) begin
                sel = FWD_EXMEM;
            end else if (mw_rw && (mw_rd != '0) && (mw_rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

    // Load-use hazard: a load in EX whose destination is read by ID.
    // The rt compare is applied even when ID only uses rs (conservative).
    always_comb begin
        load_use = 1'b0;
        if (valid_q && mem_read_q && (dest_q != '0) && id_valid) begin
            load_use = (id_rs == dest_q) || (id_rt == dest_q);
        end
    end

    // Forwarding selects for both ALU operand muxes; rt-side is produced
    // regardless of alu_src because stores need the forwarded rt data.
    always_comb begin
        Ctrl_FwdA = fwd_sel(valid_q, rs_q, exmem_reg_write, exmem_rd,
                            memwb_reg_write, memwb_rd);
        Ctrl_FwdB = fwd_sel(valid_q, rt_q, exmem_reg_write, exmem_rd,
                            memwb_reg_write, memwb_rd);
    end

    // Next contents of ID/EX: either the ID fields or an all-zero bubble.
    always_comb begin
        bubble       = flush || load_use || !id_valid;
        valid_d      = 1'b0;
        rs_data_d    = '0;
        rt_data_d    = '0;
        imm_d        = '0;
        rs_d         = '0;
        rt_d         = '0;
        dest_d       = '0;
        alu_src_d    = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_op_d     = '0;
        if (!bubble) begin
            valid_d      = 1'b1;
            rs_data_d    = id_rs_data;
            rt_data_d    = id_rt_data;
            imm_d        = id_imm;
            rs_d         = id_rs;
            rt_d         = id_rt;
            dest_d       = id_reg_dst ? id_rd : id_rt;
            alu_src_d    = id_alu_src;
            mem_read_d   = id_mem_read;
            mem_write_d  = id_mem_write;
            reg_write_d  = id_reg_write;
            mem_to_reg_d = id_mem_to_reg;
            alu_op_d     = id_alu_op;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            dest_q       <= '0;
            alu_src_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_op_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            dest_q       <= dest_d;
            alu_src_q    <= alu_src_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_op_q     <= alu_op_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_rs_data    = rs_data_q;
    assign ex_rt_data    = rt_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_dest       = dest_q;
    assign ex_alu_src    = alu_src_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_alu_op     = alu_op_q;
    assign stall         = load_use;

endmodule
